// File: rtl/demux_varredura_if.sv
// Bundle of control inputs and registered channel outputs for demux_varredura.
// The master side drives enable/mode/index/dwell; the slave (the selector) returns the outputs.
interface demux_varredura_if #(
  parameter int SEL_W    = 4,
  parameter int N_CANAIS = 16,
  parameter int DWELL_W  = 8
);

  logic                habilita;
  logic                modo;
  logic [SEL_W-1:0]    escolha;
  logic [DWELL_W-1:0]  dwell;
  logic [N_CANAIS-1:0] saida;
  logic [SEL_W-1:0]    canal;
  logic                invalido;
  logic                volta;

  modport master (
    output habilita, modo, escolha, dwell,
    input  saida, canal, invalido, volta
  );

  modport slave (
    input  habilita, modo, escolha, dwell,
    output saida, canal, invalido, volta
  );

endinterface

// File: rtl/demux_varredura.sv
// Registered one-hot channel selector: manual decode of an index, or automatic scan
// with a programmable dwell per channel and a wrap pulse at the end of each sweep.
module demux_varredura #(
  parameter int SEL_W    = 4,
  parameter int N_CANAIS = 16,
  parameter int DWELL_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_varredura_if.slave     bus_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } estado_e;

  // One extra bit so N_CANAIS == 2**SEL_W does not wrap to zero in the range check.
  localparam logic [SEL_W:0]   N_EXT  = (SEL_W+1)'(N_CANAIS);
  localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N_CANAIS - 1);

  estado_e             estado;
  logic                entrada_scan;
  logic                escolha_valida;

  logic [N_CANAIS-1:0] saida_q,    saida_d;
  logic [SEL_W-1:0]    canal_q,    canal_d;
  logic [DWELL_W-1:0]  dwell_q,    dwell_d;
  logic                invalido_q, invalido_d;
  logic                volta_q,    volta_d;
  logic                modo_q;

  // Only bits below N_CANAIS can ever be set, so the result is all-zero or one-hot.
  function automatic logic [N_CANAIS-1:0] one_hot(input logic [SEL_W-1:0] idx);
    logic [N_CANAIS-1:0] r;
    r = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      r[i] = (idx == SEL_W'(i));
    end
    return r;
  endfunction

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q    <= '0;
      canal_q    <= '0;
      dwell_q    <= '0;
      invalido_q <= 1'b0;
      volta_q    <= 1'b0;
      modo_q     <= 1'b0;
    end else begin
      saida_q    <= saida_d;
      canal_q    <= canal_d;
      dwell_q    <= dwell_d;
      invalido_q <= invalido_d;
      volta_q    <= volta_d;
      modo_q     <= bus_if.modo;
    end
  end

  // Mode decode and next-state computation
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    estado         = IDLE;
    saida_d        = '0;
    canal_d        = canal_q;
    dwell_d        = dwell_q;
    invalido_d     = invalido_q;
    volta_d        = 1'b0;
    escolha_valida = ({1'b0, bus_if.escolha} < N_EXT);

    if (bus_if.habilita) begin
      estado = bus_if.modo ? SCAN : MANUAL;
    end
    entrada_scan = (estado == SCAN) && !modo_q;

    unique case (estado)
      IDLE: begin
        // Outputs blank; channel, dwell count and invalid flag hold for resumption.
      end

      MANUAL: begin
        dwell_d = '0;
        if (escolha_valida) begin
          saida_d    = one_hot(bus_if.escolha);
          canal_d    = bus_if.escolha;
          invalido_d = 1'b0;
        end else begin
          invalido_d = 1'b1;
        end
      end

      SCAN: begin
        invalido_d = 1'b0;
        if (entrada_scan) begin
          canal_d = '0;
          dwell_d = '0;
        end else if (dwell_q < bus_if.dwell) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          // >= rather than == so a Dwell lowered mid-channel advances on the next cycle.
          dwell_d = '0;
          if (canal_q == ULTIMO) begin
            canal_d = '0;
            volta_d = 1'b1;
          end else begin
            canal_d = canal_q + 1'b1;
          end
        end
        saida_d = one_hot(canal_d);
      end

      default: begin
      end
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    bus_if.saida    = saida_q;
    bus_if.canal    = canal_q;
    bus_if.invalido = invalido_q;
    bus_if.volta    = volta_q;
  end

endmodule

// File: tb/tb_demux_varredura.sv
// Directed bench for demux_varredura: a default 16-channel instance and a 10-channel one
// share the clock; expected values are written out by hand or by simple sweep formulas.
module tb_demux_varredura;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  demux_varredura_if #(.SEL_W(4), .N_CANAIS(16), .DWELL_W(8)) a_if ();
  demux_varredura_if #(.SEL_W(4), .N_CANAIS(10), .DWELL_W(8)) b_if ();

  demux_varredura #(.SEL_W(4), .N_CANAIS(16), .DWELL_W(8)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (a_if.slave)
  );

  demux_varredura #(.SEL_W(4), .N_CANAIS(10), .DWELL_W(8)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] saida, input logic [31:0] canal,
                         input logic [31:0] invalido, input logic [31:0] volta);
    check({tag, ".saida"},    32'(a_if.saida),    saida);
    check({tag, ".canal"},    32'(a_if.canal),    canal);
    check({tag, ".invalido"}, 32'(a_if.invalido), invalido);
    check({tag, ".volta"},    32'(a_if.volta),    volta);
  endtask

  task automatic check_b(input string tag, input logic [31:0] saida, input logic [31:0] canal,
                         input logic [31:0] invalido, input logic [31:0] volta);
    check({tag, ".saida"},    32'(b_if.saida),    saida);
    check({tag, ".canal"},    32'(b_if.canal),    canal);
    check({tag, ".invalido"}, 32'(b_if.invalido), invalido);
    check({tag, ".volta"},    32'(b_if.volta),    volta);
  endtask

  initial begin
    int ch;
    rst_n         = 1'b0;
    a_if.habilita = 1'b0;
    a_if.modo     = 1'b0;
    a_if.escolha  = '0;
    a_if.dwell    = '0;
    b_if.habilita = 1'b0;
    b_if.modo     = 1'b0;
    b_if.escolha  = '0;
    b_if.dwell    = '0;

    // Reset held across two edges
    step();
    step();
    check_a("reset_a", 32'h0, 32'd0, 32'd0, 32'd0);
    check_b("reset_b", 32'h0, 32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;

    // 10-channel instance: valid, out-of-range, top valid, boundary 10
    b_if.habilita = 1'b1;
    b_if.escolha  = 4'd3;
    step();
    check_b("b_manual3", 32'h008, 32'd3, 32'd0, 32'd0);
    b_if.escolha = 4'd12;
    step();
    check_b("b_manual12", 32'h000, 32'd3, 32'd1, 32'd0);
    b_if.escolha = 4'd9;
    step();
    check_b("b_manual9", 32'h200, 32'd9, 32'd0, 32'd0);
    b_if.escolha = 4'd10;
    step();
    check_b("b_manual10", 32'h000, 32'd9, 32'd1, 32'd0);

    // 10-channel scan with Dwell=0: wrap 9 -> 0 raises Volta
    b_if.modo = 1'b1;
    step();
    check_b("b_scan_entry", 32'h001, 32'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 9; k++) step();
    check_b("b_scan_ch9", 32'h200, 32'd9, 32'd0, 32'd0);
    step();
    check_b("b_scan_wrap", 32'h001, 32'd0, 32'd0, 32'd1);
    step();
    check_b("b_scan_after", 32'h002, 32'd1, 32'd0, 32'd0);
    b_if.habilita = 1'b0;

    // Default instance untouched while disabled
    check_a("a_idle", 32'h0, 32'd0, 32'd0, 32'd0);

    // Manual decode on the default instance
    a_if.habilita = 1'b1;
    a_if.escolha  = 4'd5;
    step();
    check_a("a_manual5", 32'h0020, 32'd5, 32'd0, 32'd0);
    for (int n = 0; n < 16; n++) begin
      a_if.escolha = 4'(n);
      step();
      check("sweep.saida", 32'(a_if.saida), 32'd1 << n);
      check("sweep.canal", 32'(a_if.canal), 32'(n));
    end

    // Scan, Dwell=2: three cycles per channel, full sweep of 48 cycles
    a_if.modo  = 1'b1;
    a_if.dwell = 8'd2;
    step();
    check_a("scan_entry", 32'h0001, 32'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 48; k++) begin
      step();
      ch = (k / 3) % 16;
      check("dwell2.canal", 32'(a_if.canal), 32'(ch));
      check("dwell2.saida", 32'(a_if.saida), 32'd1 << ch);
      check("dwell2.volta", 32'(a_if.volta), (k == 48) ? 32'd1 : 32'd0);
    end

    // Manual 11, then Modo 0->1 restarts scan at channel 0
    a_if.modo    = 1'b0;
    a_if.escolha = 4'd11;
    step();
    check_a("manual11", 32'h0800, 32'd11, 32'd0, 32'd0);
    a_if.modo  = 1'b1;
    a_if.dwell = 8'd0;
    step();
    check_a("reentry", 32'h0001, 32'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 7; k++) step();
    check_a("dwell0_ch7", 32'h0080, 32'd7, 32'd0, 32'd0);

    // Pause for 4 cycles at channel 7, then resume at 8
    a_if.habilita = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_a("pause", 32'h0000, 32'd7, 32'd0, 32'd0);
    end
    a_if.habilita = 1'b1;
    step();
    check_a("resume", 32'h0100, 32'd8, 32'd0, 32'd0);

    // Back to manual: follows Escolha one cycle later
    a_if.modo    = 1'b0;
    a_if.escolha = 4'd3;
    step();
    check_a("back_manual", 32'h0008, 32'd3, 32'd0, 32'd0);

    // Asynchronous reset mid-scan at channel 6
    a_if.modo = 1'b1;
    step();
    check_a("scan2_entry", 32'h0001, 32'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 6; k++) step();
    check_a("scan2_ch6", 32'h0040, 32'd6, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_a("async_reset", 32'h0000, 32'd0, 32'd0, 32'd0);
    step();
    check_a("reset_held", 32'h0000, 32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;
    step();
    check_a("restart_ch0", 32'h0001, 32'd0, 32'd0, 32'd0);
    step();
    check_a("restart_ch1", 32'h0002, 32'd1, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
